sram_controller: RTL and testbench

Parametrised controller between the pipeline's memory stage and the external asynchronous SRAM. It converts single-word read/write requests into SRAM bus cycles with a configurable wait-state count, returns multi-word read bursts, and stalls the pipeline through a ready handshake until each access completes. It sits in the MEM stage; its memory side connects directly to the SRAM device bus.

---
 rtl/sram_controller_pkg.sv | 20 ++
 rtl/sram_controller_if.sv | 26 ++
 rtl/sram_wait_counter.sv | 27 ++
 rtl/sram_controller.sv | 125 ++++++++++++
 tb/tb_sram_controller.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_controller_pkg.sv
// Shared constants and FSM encoding for the MEM-stage SRAM controller.
// Also used by the wait counter's future cache-fill users.
package sram_controller_pkg;

   localparam int unsigned CPU_ADDR_LEN     = 32;
   localparam int unsigned SRAM_DATA_LEN    = 32;
   localparam int unsigned SRAM_ADDR_LEN    = 18;
   localparam int unsigned SRAM_SIZE        = 1 << SRAM_ADDR_LEN;
   localparam int unsigned SRAM_BURST       = 2;
   localparam int unsigned SRAM_WAIT_CYCLES = 5;
   localparam int unsigned SRAM_BASE_ADDR   = 1024;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2,
      ST_DONE  = 2'd3
   } sram_state_e;

endpackage

// File: rtl/sram_controller_if.sv
// CPU-side request/ready handshake between the MEM stage and the SRAM controller.
interface sram_controller_if
   import sram_controller_pkg::*;
#(
   parameter int unsigned DATA_W = SRAM_DATA_LEN,
   parameter int unsigned BURST  = SRAM_BURST
) ();

   logic                      rd_en;
   logic                      wr_en;
   logic [CPU_ADDR_LEN-1:0]   addr;
   logic [DATA_W-1:0]         wdata;
   logic [BURST*DATA_W-1:0]   rdata;
   logic                      ready;

   modport master (
      output rd_en, wr_en, addr, wdata,
      input  rdata, ready
   );

   modport slave (
      input  rd_en, wr_en, addr, wdata,
      output rdata, ready
   );

endinterface

// File: rtl/sram_wait_counter.sv
// Loadable down-counter with zero flag; saturates at zero.
module sram_wait_counter #(
   parameter int unsigned CNT_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_value,
   input  logic             i_dec,
   output logic             o_zero_c
);

   logic [CNT_W-1:0] r_count;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_value;
      end else if (i_dec && (r_count != '0)) begin
         r_count <= r_count - CNT_W'(1);
      end
   end

   assign o_zero_c = (r_count == '0);

endmodule

// File: rtl/sram_controller.sv
// Converts single-word CPU read/write requests into timed asynchronous SRAM
// bus cycles; reads return BURST words, ready stalls the pipeline meanwhile.
module sram_controller
   import sram_controller_pkg::*;
#(
   parameter int unsigned DATA_W      = SRAM_DATA_LEN,
   parameter int unsigned ADDR_W      = SRAM_ADDR_LEN,
   parameter int unsigned BURST       = SRAM_BURST,
   parameter int unsigned WAIT_CYCLES = SRAM_WAIT_CYCLES,
   parameter int unsigned BASE_ADDR   = SRAM_BASE_ADDR
) (
   input  logic                   clk,
   input  logic                   rst,
   sram_controller_if.slave       cpu,
   output logic [ADDR_W-1:0]      sram_addr,
   output logic                   sram_we_n,
   inout  wire  [BURST*DATA_W-1:0] sram_dq
);

   localparam int unsigned DQ_W       = BURST * DATA_W;
   localparam int unsigned BYTE_SHIFT = $clog2(DATA_W / 8);
   localparam int unsigned CNT_W      = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

   if (BURST < 1 || WAIT_CYCLES < 1) begin : g_bad_params
      $error("sram_controller: BURST and WAIT_CYCLES must be at least 1");
   end

   sram_state_e       r_state;
   sram_state_e       w_next_state;
   logic [ADDR_W-1:0] r_addr;
   logic [ADDR_W-1:0] w_word_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [DQ_W-1:0]   r_rdata;
   logic              r_we_n;
   logic              r_drive;
   logic              w_latch;
   logic              w_capture;
   logic              w_dec;
   logic              w_cnt_zero;

   // CPU byte address relative to the SRAM window, in words; offset bits drop out
   assign w_word_addr = ADDR_W'((cpu.addr - CPU_ADDR_LEN'(BASE_ADDR)) >> BYTE_SHIFT);

   sram_wait_counter #(
      .CNT_W (CNT_W)
   ) u_wait_counter (
      .clk      (clk),
      .rst      (rst),
      .i_load   (w_latch),
      .i_value  (CNT_W'(WAIT_CYCLES - 1)),
      .i_dec    (w_dec),
      .o_zero_c (w_cnt_zero)
   );

   // Next state and per-edge strobes; write wins over read in IDLE
   always_comb begin
      w_next_state = r_state;
      w_latch      = 1'b0;
      w_capture    = 1'b0;
      w_dec        = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (cpu.wr_en) begin
               w_next_state = ST_WRITE;
               w_latch      = 1'b1;
            end else if (cpu.rd_en) begin
               w_next_state = ST_READ;
               w_latch      = 1'b1;
            end
         end
         ST_READ: begin
            w_dec = 1'b1;
            if (w_cnt_zero) begin
               w_next_state = ST_DONE;
               w_capture    = 1'b1;
            end
         end
         ST_WRITE: begin
            w_dec = 1'b1;
            if (w_cnt_zero) begin
               w_next_state = ST_DONE;
            end
         end
         ST_DONE: begin
            w_next_state = ST_IDLE;
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   // Bus controls are registered from the next state so they track it exactly
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= ST_IDLE;
         r_addr  <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
         r_we_n  <= 1'b1;
         r_drive <= 1'b0;
      end else begin
         r_state <= w_next_state;
         r_we_n  <= (w_next_state != ST_WRITE);
         r_drive <= (w_next_state == ST_WRITE);
         if (w_latch) begin
            r_addr  <= w_word_addr;
            r_wdata <= cpu.wdata;
         end else if ((w_next_state != ST_READ) && (w_next_state != ST_WRITE)) begin
            r_addr <= '0;
         end
         if (w_capture) begin
            r_rdata <= sram_dq;
         end
      end
   end

   assign sram_addr = r_addr;
   assign sram_we_n = r_we_n;
   assign sram_dq   = r_drive ? DQ_W'(r_wdata) : {DQ_W{1'bz}};
   assign cpu.rdata = r_rdata;
   assign cpu.ready = (r_state == ST_DONE) ||
                      ((r_state == ST_IDLE) && !cpu.rd_en && !cpu.wr_en);

endmodule

// File: tb/tb_sram_controller.sv
// Randomized bench for sram_controller: two configurations checked against
// a transaction-level model with a behavioural SRAM on each bus.
module tb_sram_controller;

   localparam int unsigned DW   = 32;
   localparam int unsigned AW   = 18;
   localparam int unsigned W_A  = 5;
   localparam int unsigned B_A  = 2;
   localparam int unsigned W_B  = 1;
   localparam int unsigned B_B  = 4;
   localparam int unsigned BASE = 1024;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   sram_controller_if #(.DATA_W(DW), .BURST(B_A)) ifa ();
   sram_controller_if #(.DATA_W(DW), .BURST(B_B)) ifb ();

   wire  [AW-1:0]     saddr_a;
   wire  [AW-1:0]     saddr_b;
   wire               we_n_a;
   wire               we_n_b;
   wire  [B_A*DW-1:0] dq_a;
   wire  [B_B*DW-1:0] dq_b;
   logic              oe_a;
   logic              oe_b;
   logic [B_A*DW-1:0] drv_a;
   logic [B_B*DW-1:0] drv_b;

   // Behavioural SRAMs drive DQ only while the bench expects a read cycle
   assign dq_a = (oe_a && we_n_a) ? drv_a : {(B_A*DW){1'bz}};
   assign dq_b = (oe_b && we_n_b) ? drv_b : {(B_B*DW){1'bz}};

   sram_controller #(
      .DATA_W(DW), .ADDR_W(AW), .BURST(B_A), .WAIT_CYCLES(W_A), .BASE_ADDR(BASE)
   ) u_dut_a (
      .clk(clk), .rst(rst), .cpu(ifa),
      .sram_addr(saddr_a), .sram_we_n(we_n_a), .sram_dq(dq_a)
   );

   sram_controller #(
      .DATA_W(DW), .ADDR_W(AW), .BURST(B_B), .WAIT_CYCLES(W_B), .BASE_ADDR(BASE)
   ) u_dut_b (
      .clk(clk), .rst(rst), .cpu(ifb),
      .sram_addr(saddr_b), .sram_we_n(we_n_b), .sram_dq(dq_b)
   );

   int unsigned n_chk  = 0;
   int unsigned n_pass = 0;
   logic [31:0]  dev_mem [int unsigned];
   logic [31:0]  ref_mem [int unsigned];
   logic [127:0] exp_rd  [2];

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got !== exp) $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      else n_pass++;
   endtask

   function automatic int unsigned mkey(input int sel, input logic [AW-1:0] wa);
      return (32'(sel) << 20) | 32'(wa);
   endfunction

   function automatic logic [31:0] mem_rd(input bit from_dev, input int unsigned k);
      if (from_dev) return dev_mem.exists(k) ? dev_mem[k] : 32'h0;
      return ref_mem.exists(k) ? ref_mem[k] : 32'h0;
   endfunction

   // Word at wa in the most significant slot, following words descending
   function automatic logic [127:0] burst(input bit from_dev, input int sel,
                                          input logic [AW-1:0] wa, input int nb);
      logic [127:0]  v;
      logic [AW-1:0] x;
      v = '0;
      for (int i = 0; i < nb; i++) begin
         x = wa + AW'(i);
         v = v | (128'(mem_rd(from_dev, mkey(sel, x))) << ((nb - 1 - i) * 32));
      end
      return v;
   endfunction

   function automatic logic [AW-1:0] word_addr(input logic [31:0] a);
      return AW'((a - 32'(BASE)) / 4);
   endfunction

   always @(negedge clk) begin
      drv_a <= 64'(burst(1'b1, 0, saddr_a, B_A));
      drv_b <= burst(1'b1, 1, saddr_b, B_B);
      if (!we_n_a) dev_mem[mkey(0, saddr_a)] = dq_a[31:0];
      if (!we_n_b) dev_mem[mkey(1, saddr_b)] = dq_b[31:0];
   end

   function automatic logic [127:0] obs_rdata(input int sel);
      return (sel == 0) ? 128'(ifa.rdata) : 128'(ifb.rdata);
   endfunction
   function automatic logic obs_ready(input int sel);
      return (sel == 0) ? ifa.ready : ifb.ready;
   endfunction
   function automatic logic obs_we_n(input int sel);
      return (sel == 0) ? we_n_a : we_n_b;
   endfunction
   function automatic logic [AW-1:0] obs_saddr(input int sel);
      return (sel == 0) ? saddr_a : saddr_b;
   endfunction
   function automatic logic [31:0] obs_dq_lo(input int sel);
      return (sel == 0) ? dq_a[31:0] : dq_b[31:0];
   endfunction

   task automatic set_req(input int sel, input bit rd, input bit wr);
      if (sel == 0) begin ifa.rd_en = rd; ifa.wr_en = wr; end
      else          begin ifb.rd_en = rd; ifb.wr_en = wr; end
   endtask

   task automatic set_bus(input logic [31:0] a, input logic [31:0] d);
      ifa.addr = a; ifb.addr = a; ifa.wdata = d; ifb.wdata = d;
   endtask

   task automatic set_oe(input int sel, input bit v);
      if (sel == 0) oe_a = v; else oe_b = v;
   endtask

   task automatic bus_chk();
      if (we_n_a && !oe_a) chk("dq_a_released", 128'($countones(dq_a)), 128'(0));
      if (!we_n_a)         chk("dq_a_upper_zero", 128'(dq_a[63:32]), 128'(0));
      if (we_n_b && !oe_b) chk("dq_b_released", 128'($countones(dq_b)), 128'(0));
      if (!we_n_b)         chk("dq_b_upper_zero", 128'(dq_b[127:32]), 128'(0));
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
      bus_chk();
   endtask

   // One complete request: WAIT+1 edges to ready, then dropped in the DONE cycle
   task automatic access(input int sel, input bit rd, input bit wr,
                         input logic [31:0] a, input logic [31:0] d);
      int            w;
      int            nb;
      logic [AW-1:0] wa;
      logic [127:0]  old_rd;
      w      = (sel == 0) ? W_A : W_B;
      nb     = (sel == 0) ? B_A : B_B;
      wa     = word_addr(a);
      old_rd = exp_rd[sel];
      if (wr)      ref_mem[mkey(sel, wa)] = d;
      else if (rd) exp_rd[sel] = burst(1'b0, sel, wa, nb);
      set_bus(a, d);
      set_req(sel, rd, wr);
      set_oe(sel, !wr);
      #1;
      chk("ready_pending", 128'(obs_ready(sel)), 128'(0));
      for (int n = 1; n <= w + 1; n++) begin
         step();
         if (n == 1) set_bus($urandom, $urandom);
         chk("ready", 128'(obs_ready(sel)), 128'((n == w + 1) ? 1 : 0));
         if (n <= w) begin
            chk("sram_addr", 128'(obs_saddr(sel)), 128'(wa));
            chk("sram_we_n", 128'(obs_we_n(sel)), 128'(wr ? 0 : 1));
            chk("rdata_hold", obs_rdata(sel), old_rd);
            if (wr) chk("dq_wdata", 128'(obs_dq_lo(sel)), 128'(d));
         end
      end
      chk("rdata", obs_rdata(sel), exp_rd[sel]);
      if (wr) chk("sram_word", 128'(mem_rd(1'b1, mkey(sel, wa))), 128'(d));
      set_req(sel, 1'b0, 1'b0);
      set_oe(sel, 1'b0);
      step();
      chk("idle_ready", 128'(obs_ready(sel)), 128'(1));
      chk("idle_addr", 128'(obs_saddr(sel)), 128'(0));
   endtask

   initial begin
      int            sel;
      int            op;
      logic [31:0]   a;
      rst = 1'b0;
      oe_a = 1'b0; oe_b = 1'b0;
      set_bus(32'h0, 32'h0);
      set_req(0, 1'b1, 1'b0);
      set_req(1, 1'b1, 1'b0);
      exp_rd[0] = '0; exp_rd[1] = '0;

      // Reset held with a read pending
      repeat (3) step();
      chk("rst_ready", 128'(ifa.ready), 128'(0));
      chk("rst_we_n", 128'(we_n_a), 128'(1));
      chk("rst_rdata", 128'(ifa.rdata), 128'(0));
      chk("rst_addr", 128'(saddr_a), 128'(0));
      set_req(0, 1'b0, 1'b0);
      set_req(1, 1'b0, 1'b0);
      rst = 1'b1;
      step();
      chk("post_rst_ready", 128'(ifa.ready), 128'(1));

      // Directed sequence on the WAIT=5, BURST=2 controller
      access(0, 1'b0, 1'b1, 32'd1024, 32'hDEADBEEF);
      access(0, 1'b0, 1'b1, 32'd1028, 32'h12345678);
      access(0, 1'b1, 1'b0, 32'd1024, 32'h0);
      chk("rd_deadbeef", obs_rdata(0), 128'h0000_0000_0000_0000_DEAD_BEEF_1234_5678);
      access(0, 1'b1, 1'b1, 32'd1032, 32'hA5A5A5A5);
      chk("rdwr_keeps_rdata", obs_rdata(0), 128'h0000_0000_0000_0000_DEAD_BEEF_1234_5678);
      access(0, 1'b1, 1'b0, 32'd1035, 32'h0);

      // Reset asserted in the third READ cycle
      set_bus(32'd1024, 32'h0);
      set_req(0, 1'b1, 1'b0);
      oe_a = 1'b1;
      repeat (3) step();
      rst = 1'b0;
      step();
      chk("abort_addr", 128'(saddr_a), 128'(0));
      chk("abort_we_n", 128'(we_n_a), 128'(1));
      chk("abort_rdata", 128'(ifa.rdata), 128'(0));
      chk("abort_ready", 128'(ifa.ready), 128'(0));
      set_req(0, 1'b0, 1'b0);
      oe_a = 1'b0;
      rst = 1'b1;
      exp_rd[0] = '0; exp_rd[1] = '0;
      step();
      access(0, 1'b1, 1'b0, 32'd1024, 32'h0);
      chk("read_after_abort", obs_rdata(0), 128'h0000_0000_0000_0000_DEAD_BEEF_1234_5678);

      // WAIT=1, BURST=4 controller: four words then one burst read
      for (int i = 0; i < 4; i++) access(1, 1'b0, 1'b1, BASE + 32'(4 * i), $urandom);
      access(1, 1'b1, 1'b0, BASE + 32'($urandom_range(0, 3)), 32'h0);

      // Randomized mix on both configurations
      for (int i = 0; i < 40; i++) begin
         sel = int'($urandom_range(0, 1));
         op  = int'($urandom_range(0, 3));
         a   = BASE + 32'($urandom_range(0, 127));
         if ($urandom_range(0, 7) == 0) a = $urandom;
         access(sel, (op != 2), (op >= 2), a, $urandom);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
